priv_1_12_trap_sequencer: RTL and testbench

Trap-entry and trap-return controller for the v1.12 privilege block. It latches a pending exception, interrupt or mret and waits for the pipeline to drain. It then performs the atomic CSR update (mcause/mepc/mtval/mstatus) through the inject strobes and redirects fetch with a one-cycle insert_pc pulse. It sits between the interrupt/exception handler, the CSR file and the pipeline control.

---
 rtl/machine_mode_types_1_12_pkg.sv | 22 ++
 rtl/priv_1_12_tvec_calc.sv | 27 ++
 rtl/priv_1_12_trap_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_priv_1_12_trap_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types and constants for the v1.12 machine-mode privilege block.
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    TRAP_EXC  = 2'd0,
    TRAP_INT  = 2'd1,
    TRAP_MRET = 2'd2
  } trap_kind_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } trap_seq_state_t;

  localparam logic [1:0] M_LEVEL = 2'b11;
  localparam logic [1:0] U_LEVEL = 2'b00;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/priv_1_12_tvec_calc.sv
// Fetch-redirect target: trap vector (direct or vectored) or the saved mepc for mret.
module priv_1_12_tvec_calc
  import machine_mode_types_1_12_pkg::*;
(
  input  logic [29:0] mtvec_base,
  input  logic [1:0]  mtvec_mode,
  input  logic        is_int,
  input  logic        is_mret,
  input  logic [29:0] cause_lo,
  input  logic [31:0] mepc,
  output logic [31:0] priv_pc
);

  logic [31:0] base_addr;

  always_comb begin
    base_addr = {mtvec_base, 2'b00};
    priv_pc   = base_addr;
    if (is_mret) begin
      priv_pc = mepc;
    end else if ((mtvec_mode == MTVEC_MODE_VECTORED) && is_int) begin
      // Reserved modes fall back to direct; only interrupts are vectored.
      priv_pc = base_addr + {cause_lo, 2'b00};
    end
  end

endmodule

// File: rtl/priv_1_12_trap_sequencer.sv
// Trap entry / mret sequencer: latch request, drain pipeline, commit CSR update, redirect fetch.
module priv_1_12_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_req,
  input  logic        int_req,
  input  logic        mret_req,
  input  logic [30:0] cause,
  input  logic [31:0] epc,
  input  logic [31:0] tval,
  input  logic        pipe_clear,
  input  logic [1:0]  curr_priv,
  input  logic [29:0] curr_mtvec_base,
  input  logic [1:0]  curr_mtvec_mode,
  input  logic [31:0] curr_mepc,
  input  logic        curr_mie_bit,
  input  logic        curr_mpie_bit,
  input  logic [1:0]  curr_mpp,
  output logic        inject_mcause,
  output logic        inject_mepc,
  output logic        inject_mtval,
  output logic        inject_mstatus,
  output logic [31:0] next_mcause,
  output logic [31:0] next_mepc,
  output logic [31:0] next_mtval,
  output logic        next_mie_bit,
  output logic        next_mpie_bit,
  output logic [1:0]  next_mpp,
  output logic [1:0]  next_priv,
  output logic        priv_update,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        busy,
  output logic        drain_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DRAIN_TIMEOUT);

  trap_seq_state_t state_q, state_d;
  trap_kind_t      kind_q, kind_d;
  logic [30:0]     cause_q, cause_d;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     tval_q, tval_d;
  logic [31:0]     mepc_q, mepc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic            is_int;
  logic            is_mret;
  logic [31:0]     calc_pc;
  logic            unused_epc_bits;

  assign is_int          = (kind_q == TRAP_INT);
  assign is_mret         = (kind_q == TRAP_MRET);
  assign unused_epc_bits = &{1'b0, epc_q[1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      kind_q    <= TRAP_EXC;
      cause_q   <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      mepc_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      mepc_q    <= mepc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    mepc_d    = mepc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (ex_req || int_req || mret_req) begin
          state_d = DRAIN;
          cnt_d   = '0;
          cause_d = cause;
          epc_d   = epc;
          tval_d  = '0;
          if (ex_req) begin
            kind_d = TRAP_EXC;
            tval_d = tval;
          end else if (int_req) begin
            kind_d = TRAP_INT;
          end else begin
            kind_d = TRAP_MRET;
          end
        end
      end
      DRAIN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (cnt_d >= CNT_LIMIT) begin
          timeout_d = 1'b1;
        end
        // A synchronous exception pre-empts a pending interrupt or mret without restarting the drain.
        if (ex_req && (kind_q != TRAP_EXC)) begin
          kind_d  = TRAP_EXC;
          cause_d = cause;
          epc_d   = epc;
          tval_d  = tval;
        end
        if (pipe_clear) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        mepc_d  = curr_mepc;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  priv_1_12_tvec_calc u_tvec_calc (
    .mtvec_base (curr_mtvec_base),
    .mtvec_mode (curr_mtvec_mode),
    .is_int     (is_int),
    .is_mret    (is_mret),
    .cause_lo   (cause_q[29:0]),
    .mepc       (mepc_q),
    .priv_pc    (calc_pc)
  );

  always_comb begin
    inject_mcause  = 1'b0;
    inject_mepc    = 1'b0;
    inject_mtval   = 1'b0;
    inject_mstatus = 1'b0;
    next_mcause    = '0;
    next_mepc      = '0;
    next_mtval     = '0;
    next_mie_bit   = 1'b0;
    next_mpie_bit  = 1'b0;
    next_mpp       = '0;
    next_priv      = '0;
    priv_update    = 1'b0;
    insert_pc      = 1'b0;
    priv_pc        = '0;

    if (state_q == COMMIT) begin
      inject_mstatus = 1'b1;
      priv_update    = 1'b1;
      if (is_mret) begin
        next_mie_bit  = curr_mpie_bit;
        next_mpie_bit = 1'b1;
        next_mpp      = U_LEVEL;
        next_priv     = curr_mpp;
      end else begin
        inject_mcause = 1'b1;
        inject_mepc   = 1'b1;
        inject_mtval  = 1'b1;
        next_mcause   = {is_int, cause_q};
        next_mepc     = {epc_q[31:2], 2'b00};
        next_mtval    = tval_q;
        next_mpie_bit = curr_mie_bit;
        next_mpp      = curr_priv;
        next_priv     = M_LEVEL;
      end
    end else if (state_q == REDIRECT) begin
      insert_pc = 1'b1;
      priv_pc   = calc_pc;
    end
  end

  assign busy          = (state_q != IDLE);
  assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Directed bench for the trap sequencer: trap, vectored interrupt, mret, drain timeout, override, reset.
module tb_priv_1_12_trap_sequencer;

  logic        CLK;
  logic        nRST;
  logic        ex_req, int_req, mret_req;
  logic [30:0] cause;
  logic [31:0] epc, tval;
  logic        pipe_clear;
  logic [1:0]  curr_priv;
  logic [29:0] curr_mtvec_base;
  logic [1:0]  curr_mtvec_mode;
  logic [31:0] curr_mepc;
  logic        curr_mie_bit, curr_mpie_bit;
  logic [1:0]  curr_mpp;
  logic        inject_mcause, inject_mepc, inject_mtval, inject_mstatus;
  logic [31:0] next_mcause, next_mepc, next_mtval;
  logic        next_mie_bit, next_mpie_bit;
  logic [1:0]  next_mpp, next_priv;
  logic        priv_update, insert_pc, busy, drain_timeout;
  logic [31:0] priv_pc;

  int errors = 0;
  int checks = 0;

  priv_1_12_trap_sequencer #(.DRAIN_TIMEOUT(64), .CNT_W(7)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .ex_req          (ex_req),
    .int_req         (int_req),
    .mret_req        (mret_req),
    .cause           (cause),
    .epc             (epc),
    .tval            (tval),
    .pipe_clear      (pipe_clear),
    .curr_priv       (curr_priv),
    .curr_mtvec_base (curr_mtvec_base),
    .curr_mtvec_mode (curr_mtvec_mode),
    .curr_mepc       (curr_mepc),
    .curr_mie_bit    (curr_mie_bit),
    .curr_mpie_bit   (curr_mpie_bit),
    .curr_mpp        (curr_mpp),
    .inject_mcause   (inject_mcause),
    .inject_mepc     (inject_mepc),
    .inject_mtval    (inject_mtval),
    .inject_mstatus  (inject_mstatus),
    .next_mcause     (next_mcause),
    .next_mepc       (next_mepc),
    .next_mtval      (next_mtval),
    .next_mie_bit    (next_mie_bit),
    .next_mpie_bit   (next_mpie_bit),
    .next_mpp        (next_mpp),
    .next_priv       (next_priv),
    .priv_update     (priv_update),
    .insert_pc       (insert_pc),
    .priv_pc         (priv_pc),
    .busy            (busy),
    .drain_timeout   (drain_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST            = 1'b0;
    ex_req          = 1'b0;
    int_req         = 1'b0;
    mret_req        = 1'b0;
    cause           = '0;
    epc             = '0;
    tval            = '0;
    pipe_clear      = 1'b1;
    curr_priv       = 2'b00;
    curr_mtvec_base = 30'h0000_0400;
    curr_mtvec_mode = 2'd0;
    curr_mepc       = '0;
    curr_mie_bit    = 1'b1;
    curr_mpie_bit   = 1'b0;
    curr_mpp        = 2'b00;
    tick();
    tick();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_inject", {28'd0, inject_mcause, inject_mepc, inject_mtval, inject_mstatus}, 32'd0);
    check_val("rst_insert_pc", {31'd0, insert_pc}, 32'd0);
    nRST = 1'b1;
    tick();

    // Exception beats a simultaneous interrupt; direct mode from U.
    ex_req = 1'b1; int_req = 1'b1; cause = 31'd2; epc = 32'h0000_1006; tval = 32'hDEAD_BEEF;
    check_val("exc_c0_busy", {31'd0, busy}, 32'd0);
    tick();
    ex_req = 1'b0; int_req = 1'b0;
    check_val("exc_c1_busy", {31'd0, busy}, 32'd1);
    check_val("exc_c1_no_inject", {31'd0, inject_mcause}, 32'd0);
    tick();
    check_val("exc_inject", {28'd0, inject_mcause, inject_mepc, inject_mtval, inject_mstatus}, 32'hF);
    check_val("exc_mcause", next_mcause, 32'h0000_0002);
    check_val("exc_mepc", next_mepc, 32'h0000_1004);
    check_val("exc_mtval", next_mtval, 32'hDEAD_BEEF);
    check_val("exc_mpp", {30'd0, next_mpp}, 32'd0);
    check_val("exc_priv", {30'd0, next_priv}, 32'd3);
    check_val("exc_mie_mpie", {30'd0, next_mie_bit, next_mpie_bit}, 32'd1);
    check_val("exc_priv_update", {31'd0, priv_update}, 32'd1);
    check_val("exc_commit_no_insert", {31'd0, insert_pc}, 32'd0);
    tick();
    check_val("exc_insert_pc", {31'd0, insert_pc}, 32'd1);
    check_val("exc_priv_pc", priv_pc, 32'h0000_1000);
    check_val("exc_redirect_no_inject", {31'd0, inject_mcause}, 32'd0);
    tick();
    check_val("exc_idle_busy", {31'd0, busy}, 32'd0);
    check_val("exc_idle_insert", {31'd0, insert_pc}, 32'd0);

    // Vectored interrupt from M; mtval must be zero even with a non-zero tval input.
    curr_priv = 2'b11; curr_mtvec_mode = 2'd1;
    int_req = 1'b1; cause = 31'd7; epc = 32'h0000_0200; tval = 32'h1234_5678;
    tick();
    int_req = 1'b0;
    tick();
    check_val("int_mcause", next_mcause, 32'h8000_0007);
    check_val("int_mtval", next_mtval, 32'h0000_0000);
    check_val("int_mpp", {30'd0, next_mpp}, 32'd3);
    tick();
    check_val("int_priv_pc", priv_pc, 32'h0000_101C);
    tick();

    // mret: only mstatus written, return target latched in COMMIT.
    curr_mtvec_mode = 2'd0;
    mret_req = 1'b1; curr_mpie_bit = 1'b1; curr_mpp = 2'b00; curr_mepc = 32'h0000_2000;
    tick();
    mret_req = 1'b0;
    tick();
    check_val("mret_inject", {28'd0, inject_mcause, inject_mepc, inject_mtval, inject_mstatus}, 32'h1);
    check_val("mret_mie_mpie", {30'd0, next_mie_bit, next_mpie_bit}, 32'd3);
    check_val("mret_mpp", {30'd0, next_mpp}, 32'd0);
    check_val("mret_priv", {30'd0, next_priv}, 32'd0);
    check_val("mret_mcause_zero", next_mcause, 32'd0);
    tick();
    curr_mepc = 32'h0000_5554;
    #1;
    check_val("mret_priv_pc", priv_pc, 32'h0000_2000);
    tick();

    // Drain stall past the timeout.
    ex_req = 1'b1; pipe_clear = 1'b0; cause = 31'd4; epc = 32'h0000_0300; tval = 32'h0;
    tick();
    ex_req = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 64) check_val("drain_to_k64", {31'd0, drain_timeout}, 32'd0);
      if (k == 65) check_val("drain_to_k65", {31'd0, drain_timeout}, 32'd1);
      if (k == 70) begin
        check_val("drain_k70_busy_no_commit", {30'd0, busy, inject_mcause}, 32'd2);
        pipe_clear = 1'b1;
      end
      tick();
    end
    check_val("drain_commit", {31'd0, inject_mcause}, 32'd1);
    check_val("drain_commit_to", {31'd0, drain_timeout}, 32'd1);
    tick();
    tick();
    check_val("drain_idle_to_clr", {30'd0, busy, drain_timeout}, 32'd0);

    // Exception overrides a latched interrupt during drain.
    curr_mtvec_mode = 2'd1;
    int_req = 1'b1; pipe_clear = 1'b0; cause = 31'd3; epc = 32'h0000_0100;
    tick();
    int_req = 1'b0;
    tick();
    ex_req = 1'b1; cause = 31'd5; epc = 32'h0000_0040; tval = 32'h0000_0099;
    tick();
    ex_req = 1'b0; pipe_clear = 1'b1;
    check_val("ovr_still_drain", {31'd0, inject_mcause}, 32'd0);
    tick();
    check_val("ovr_mcause", next_mcause, 32'h0000_0005);
    check_val("ovr_mtval", next_mtval, 32'h0000_0099);
    check_val("ovr_mepc", next_mepc, 32'h0000_0040);
    tick();
    check_val("ovr_priv_pc", priv_pc, 32'h0000_1000);
    tick();
    curr_mtvec_mode = 2'd0;

    // Asynchronous reset during COMMIT.
    ex_req = 1'b1; cause = 31'd1; epc = 32'h0000_0800; tval = 32'h1;
    tick();
    ex_req = 1'b0;
    tick();
    check_val("rstc_commit", {31'd0, inject_mcause}, 32'd1);
    nRST = 1'b0;
    #1;
    check_val("rstc_inject", {28'd0, inject_mcause, inject_mepc, inject_mtval, inject_mstatus}, 32'd0);
    check_val("rstc_priv_update_busy", {30'd0, priv_update, busy}, 32'd0);
    check_val("rstc_next_mcause", next_mcause, 32'd0);
    tick();
    nRST = 1'b1;
    tick();
    check_val("rstc_no_insert1", {30'd0, insert_pc, busy}, 32'd0);
    tick();
    check_val("rstc_no_insert2", {30'd0, insert_pc, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
